// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 size codes,
// responder FSM states and the core-side load/store opcodes.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_if.sv
// Core <-> data-memory request/response bundle.
// Handshake: a beat transfers on a posedge where valid && ready; the sender
// holds its payload stable while valid is high and ready is low.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_sel.sv
// Combinational byte-lane steering: write strobes/data, load extraction and
// extension, illegal-funct3 and misalign flags. Macro: DMEM_MISALIGN_CHECK_EN.
module dmem_lane_sel
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic        is_half;
    logic        is_word;
    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        is_half = (funct3 == F3_H) || (funct3 == F3_HU);
        is_word = (funct3 == F3_W);

        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = write;
            default:          illegal = 1'b1;
        endcase

`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
        off      = addr_lo;
`else
        // Without the check, low address bits are silently forced to the access size.
        misalign = 1'b0;
        off      = is_word ? 2'b00 : (is_half ? {addr_lo[1], 1'b0} : addr_lo);
`endif

        shifted = rword >> {off, 3'b000};

        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
            F3_W:    rdata_ext = shifted;
            default: rdata_ext = 32'h0;
        endcase

        case (funct3)
            F3_B: begin
                wstrb      = 4'b0001 << off;
                wdata_lane = {4{wdata[7:0]}};
            end
            F3_H: begin
                wstrb      = off[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            F3_W: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata;
            end
            default: begin
                wstrb      = 4'b0000;
                wdata_lane = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Optional misaligned-access faulting via `define DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus,
    output state_e dbg_state
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    state_e      state, state_nx;
    logic [3:0]  cnt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;

    logic [AW-1:0] idx;
    logic          oor;
    logic          err;
    logic          commit;
    logic [3:0]    wstrb;
    logic [31:0]   wdata_lane;
    logic [31:0]   rdata_ext;
    logic          misalign;
    logic          illegal;

    assign idx    = addr_q[AW+1:2];
    assign oor    = |addr_q[31:AW+2];
    assign err    = illegal | misalign | oor;
    assign commit = (state == WAIT) && (cnt == 4'd0);

    dmem_lane_sel u_lane_sel (
        .funct3     (funct3_q),
        .write      (write_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rword      (mem[idx]),
        .wstrb      (wstrb),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign),
        .illegal    (illegal)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nx = WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            write_q       <= 1'b0;
            addr_q        <= 32'h0;
            wdata_q       <= 32'h0;
            funct3_q      <= 3'b000;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.req_valid) begin
                write_q  <= bus.req_write;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                funct3_q <= bus.req_funct3;
                cnt      <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                bus.rsp_rdata <= (err || write_q) ? 32'h0 : rdata_ext;
                bus.rsp_err   <= err;
            end
        end
    end

    // Gated by rst so a store still in WAIT when reset hits is never written.
    always_ff @(posedge clk) begin
        if (!rst && commit && write_q && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == RESP);
    assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-level reference model, directed
// cases followed by randomized loads/stores with random response backpressure.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 2;
    localparam int WIN         = 64;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if bus();
    state_e dbg_state;

    dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] exp_q[$];
    int          acc_q[$];
    logic [7:0]  mbytes [WIN];

    bit hold_low = 1'b0;
    bit rand_bp  = 1'b0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%09h expected 0x%09h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as bytes, access rules applied directly; returns {err, rdata}.
    function automatic logic [32:0] model(input bit wr, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [2:0] f3);
        int          size;
        bit          sgn;
        bit          legal;
        logic [31:0] a;
        logic [31:0] v;
        size = 1; sgn = 1'b0; legal = 1'b1; a = addr; v = 32'h0;
        case (f3)
            3'b000: begin size = 1; sgn = 1'b1; end
            3'b001: begin size = 2; sgn = 1'b1; end
            3'b010: begin size = 4; end
            3'b100: begin size = 1; legal = !wr; end
            3'b101: begin size = 2; legal = !wr; end
            default: legal = 1'b0;
        endcase
        if (!legal) return {1'b1, 32'h0};
        if (addr >= 32'(4 * DEPTH_WORDS)) return {1'b1, 32'h0};
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((addr % size) != 0) return {1'b1, 32'h0};
`else
        a = addr - (addr % size);
`endif
        if (wr) begin
            for (int i = 0; i < size; i++) mbytes[a + i] = wdata[8*i +: 8];
            return {1'b0, 32'h0};
        end
        for (int i = 0; i < size; i++) v[8*i +: 8] = mbytes[a + i];
        if (sgn && v[8*size - 1]) for (int i = 8*size; i < 32; i++) v[i] = 1'b1;
        return {1'b0, v};
    endfunction

    // response-side ready driver
    always @(posedge clk) begin
        #1;
        if (hold_low)     bus.rsp_ready = 1'b0;
        else if (rand_bp) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        else              bus.rsp_ready = 1'b1;
    end

    // driver
    task automatic send(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input bit expect_rsp);
        int n;
        int c;
        if (expect_rsp) exp_q.push_back(model(wr, addr, wdata, f3));
        @(posedge clk); #1;
        bus.req_write  = wr;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_funct3 = f3;
        bus.req_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
            bus.req_valid = 1'b0;
            return;
        end
        c = cyc;
        @(posedge clk);
        if (expect_rsp) acc_q.push_back(c);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    // monitor / scoreboard
    logic        prev_valid = 1'b0;
    logic [32:0] held;
    logic [32:0] e;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.rsp_valid && !prev_valid) begin
                if (acc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp_valid: got 1 required 0");
                end else begin
                    check("latency", 33'(cyc - acc_q.pop_front()), 33'(LATENCY + 1));
                end
                held = {bus.rsp_err, bus.rsp_rdata};
            end else if (bus.rsp_valid) begin
                check("rsp_hold_stable", {bus.rsp_err, bus.rsp_rdata}, held);
                check("req_ready_in_resp", 33'(bus.req_ready), 33'(0));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rsp_without_expect: got a response, required none");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", {bus.rsp_err, bus.rsp_rdata}, e);
                end
            end
            prev_valid = bus.rsp_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [2:0]  f3;
        logic [31:0] addr;
        bit          wr;

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_funct3 = 3'b000;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < WIN; i++) mbytes[i] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 33'(bus.req_ready), 33'(0));
        check("reset_rsp_valid", 33'(bus.rsp_valid), 33'(0));
        check("reset_rsp", {bus.rsp_err, bus.rsp_rdata}, 33'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_reset", 33'(bus.req_ready), 33'(1));

        // clear the modelled window
        for (int w = 0; w < WIN / 4; w++) send(1'b1, 32'(4 * w), 32'h0, F3_W, 1'b1);
        wait_drain();

        // store/load, lanes, extension, alignment, errors
        send(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 1'b1);
        send(1'b0, 32'h10, 32'h0, F3_W, 1'b1);
        send(1'b1, 32'h13, 32'h80, F3_B, 1'b1);
        send(1'b0, 32'h13, 32'h0, F3_B, 1'b1);
        send(1'b0, 32'h13, 32'h0, F3_BU, 1'b1);
        send(1'b0, 32'h10, 32'h0, F3_HU, 1'b1);
        send(1'b0, 32'h12, 32'h0, F3_H, 1'b1);
        send(1'b0, 32'h12, 32'h0, F3_W, 1'b1);
        send(1'b1, 32'(4 * DEPTH_WORDS), 32'h55AA55AA, F3_W, 1'b1);
        send(1'b0, 32'h0, 32'h0, F3_W, 1'b1);
        send(1'b1, 32'h14, 32'h77, F3_BU, 1'b1);
        send(1'b0, 32'h14, 32'h0, 3'b011, 1'b1);
        send(1'b0, 32'h14, 32'h0, F3_W, 1'b1);
        wait_drain();

        // backpressure with an ignored request while RESP is held
        hold_low = 1'b1;
        send(1'b0, 32'h10, 32'h0, F3_W, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid_seen", 33'(bus.rsp_valid), 33'(1));
        @(posedge clk); #1;
        bus.req_write  = 1'b1;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'hFFFFFFFF;
        bus.req_funct3 = F3_W;
        bus.req_valid  = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        hold_low = 1'b0;
        wait_drain();
        send(1'b0, 32'h30, 32'h0, F3_W, 1'b1);
        wait_drain();

        // reset while a store waits to commit
        send(1'b1, 32'h20, 32'h1234, F3_W, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_req_ready", 33'(bus.req_ready), 33'(0));
        check("midreset_rsp_valid", 33'(bus.rsp_valid), 33'(0));
        check("midreset_rsp", {bus.rsp_err, bus.rsp_rdata}, 33'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (LATENCY + 2) @(negedge clk);
        check("midreset_no_late_rsp", 33'(bus.rsp_valid), 33'(0));
        send(1'b0, 32'h20, 32'h0, F3_W, 1'b1);
        wait_drain();

        // randomized traffic with random response backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            wr = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 11))
                0, 1:    f3 = F3_B;
                2, 3:    f3 = F3_H;
                4, 5, 6: f3 = F3_W;
                7:       f3 = F3_BU;
                8:       f3 = F3_HU;
                9:       f3 = 3'b011;
                10:      f3 = 3'b110;
                default: f3 = 3'b111;
            endcase
            if ($urandom_range(0, 9) == 0) addr = 32'h1000 + 32'($urandom_range(0, 255));
            else                           addr = 32'($urandom_range(0, WIN - 1));
            send(wr, addr, $urandom, f3, 1'b1);
        end
        wait_drain();
        rand_bp = 1'b0;

        // read back the whole window against the model
        for (int w = 0; w < WIN / 4; w++) send(1'b0, 32'(4 * w), 32'h0, F3_W, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
